// File: rtl/ami_alen_partition_mc.sv
// Multi-channel AXI INCR burst partitioner: round-robin command intake, bursts split at MAX_BLEN / 4KB / length.
// Optional macro AMI_UNALIGNED_EN: honour unaligned start addresses on the first burst of a command.
module ami_alen_partition_mc #(
    parameter int unsigned AXI_DW     = 128,
    parameter int unsigned AXI_AW     = 32,
    parameter int unsigned AXI_IW     = 8,
    parameter int unsigned AXI_LW     = 8,
    parameter int unsigned AXI_SW     = 3,
    parameter int unsigned AXI_BURSTW = 2,
    parameter int unsigned CH_N       = 4,
    parameter int unsigned MAX_BLEN   = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CH_N-1:0]       cfg_valid,
    output logic [CH_N-1:0]       cfg_ready,
    input  logic [CH_N*32-1:0]    cfg_sa,
    input  logic [CH_N*32-1:0]    cfg_len,
    output logic [AXI_IW-1:0]     ax_id,
    output logic [AXI_AW-1:0]     ax_addr,
    output logic [AXI_LW-1:0]     ax_len,
    output logic [AXI_SW-1:0]     ax_size,
    output logic [AXI_BURSTW-1:0] ax_burst,
    output logic                  ax_valid,
    input  logic                  ax_ready,
    output logic [CH_N-1:0]       done,
    output logic                  busy
);
    localparam int unsigned AXI_BYTES = AXI_DW / 8;
    localparam int unsigned OFFW      = $clog2(AXI_BYTES);
    localparam int unsigned CHW       = (CH_N > 1) ? $clog2(CH_N) : 1;
    localparam logic [AXI_AW-1:0] AMASK = AXI_AW'(AXI_BYTES - 1);
    localparam logic [31:0]       OMASK = 32'(AXI_BYTES - 1);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [CHW-1:0]    rr_q, rr_d, id_q, id_d;
    logic [AXI_AW-1:0] addr_q, addr_d;
    logic [31:0]       rem_q, rem_d;
    logic [AXI_LW:0]   blen_q, blen_d;
    logic [CH_N-1:0]   done_q, done_d;

    logic              gnt_vld;
    logic [CHW-1:0]    gnt;
    logic [2*CH_N-1:0] vrot;
    int unsigned       gidx;
    logic [31:0]       sa_sel, len_sel, off, beats, cand, rem_nx;
    logic [33:0]       bsum;
    logic [AXI_AW-1:0] addr_al;
    logic [12:0]       bnd;

    // Rotate valids so bit 0 is the current highest-priority channel.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        gidx    = 0;
        vrot    = {cfg_valid, cfg_valid} >> rr_q;
        for (int unsigned i = 0; i < CH_N; i++) begin
            if (!gnt_vld && vrot[i]) begin
                gnt_vld = 1'b1;
                gidx    = 32'(rr_q) + i;
                if (gidx >= CH_N) gidx = gidx - CH_N;
                gnt     = CHW'(gidx);
            end
        end
    end

    always_comb begin
        cfg_ready = '0;
        sa_sel    = '0;
        len_sel   = '0;
        for (int unsigned i = 0; i < CH_N; i++) begin
            cfg_ready[i] = (state_q == IDLE) && gnt_vld && (32'(gnt) == i);
            if (cfg_ready[i]) begin
                sa_sel  = cfg_sa[32*i +: 32];
                len_sel = cfg_len[32*i +: 32];
            end
        end
    end

`ifdef AMI_UNALIGNED_EN
    assign off = sa_sel & OMASK;
`else
    assign off = '0;
`endif
    assign bsum    = 34'(off) + 34'(len_sel) + 34'(AXI_BYTES - 1);
    assign beats   = (len_sel == '0) ? '0 : 32'(bsum >> OFFW);
    assign addr_al = addr_q & ~AMASK;
    assign bnd     = 13'd4096 - {1'b0, addr_al[11:0]};

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        blen_d  = blen_q;
        done_d  = '0;
        cand    = rem_q;
        rem_nx  = rem_q - 32'(blen_q);
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    id_d  = gnt;
                    rr_d  = (gnt == CHW'(CH_N - 1)) ? '0 : gnt + CHW'(1);
`ifdef AMI_UNALIGNED_EN
                    addr_d = sa_sel[AXI_AW-1:0];
`else
                    addr_d = sa_sel[AXI_AW-1:0] & ~AMASK;
`endif
                    rem_d = beats;
                    if (beats == '0) done_d = CH_N'(1) << gnt;
                    else             state_d = CALC;
                end
            end
            CALC: begin
                if (32'(MAX_BLEN) < cand)   cand = 32'(MAX_BLEN);
                if (32'(bnd >> OFFW) < cand) cand = 32'(bnd >> OFFW);
                blen_d  = (AXI_LW+1)'(cand);
                state_d = ISSUE;
            end
            ISSUE: begin
                if (ax_ready) begin
                    // Follow-on bursts always start from the aligned-down address.
                    addr_d = addr_al + (AXI_AW'(blen_q) << OFFW);
                    rem_d  = rem_nx;
                    if (rem_nx == '0) begin
                        done_d  = CH_N'(1) << id_q;
                        state_d = IDLE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            blen_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            blen_q  <= blen_d;
            done_q  <= done_d;
        end
    end

    assign ax_valid = (state_q == ISSUE);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign ax_id    = AXI_IW'(id_q);
    assign ax_addr  = addr_q;
    assign ax_len   = (blen_q == '0) ? '0 : AXI_LW'(blen_q - (AXI_LW+1)'(1));
    assign ax_size  = AXI_SW'(OFFW);
    assign ax_burst = AXI_BURSTW'(1);
endmodule

// File: tb/tb_ami_alen_partition_mc.sv
// Self-checking bench for ami_alen_partition_mc (AXI_DW=128, CH_N=2, MAX_BLEN=256).
module tb_ami_alen_partition_mc;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  cfg_valid = '0;
    logic [1:0]  cfg_ready;
    logic [63:0] cfg_sa = '0;
    logic [63:0] cfg_len = '0;
    logic [7:0]  ax_id, ax_len;
    logic [31:0] ax_addr;
    logic [2:0]  ax_size;
    logic [1:0]  ax_burst;
    logic        ax_valid;
    logic        ax_ready = 1'b0;
    logic [1:0]  done;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];

    always #5 clk = ~clk;

    ami_alen_partition_mc #(.AXI_DW(128), .CH_N(2), .MAX_BLEN(256)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sa(cfg_sa), .cfg_len(cfg_len),
        .ax_id(ax_id), .ax_addr(ax_addr), .ax_len(ax_len), .ax_size(ax_size), .ax_burst(ax_burst),
        .ax_valid(ax_valid), .ax_ready(ax_ready), .done(done), .busy(busy)
    );

    // Byte-domain reference: walk the byte span in chunks capped by 4KB pages.
    task automatic build_model(input logic [31:0] sa, input logic [31:0] len);
        longint unsigned bytes, chunk, room;
        logic [31:0] cur, off;
        bit first;
        exp_addr.delete();
        exp_len.delete();
        cur = sa & 32'hFFFF_FFF0;
`ifdef AMI_UNALIGNED_EN
        off = sa & 32'hF;
`else
        off = 32'h0;
`endif
        bytes = (len == 0) ? 0 : ((64'(off) + 64'(len) + 15) / 16) * 16;
        first = 1'b1;
        while (bytes > 0) begin
            room  = 4096 - (64'(cur) % 4096);
            chunk = bytes;
            if (chunk > 4096) chunk = 4096;
            if (chunk > room) chunk = room;
`ifdef AMI_UNALIGNED_EN
            exp_addr.push_back(first ? sa : cur);
`else
            exp_addr.push_back(cur);
`endif
            exp_len.push_back(8'(chunk / 16 - 1));
            cur   = cur + 32'(chunk);
            bytes = bytes - chunk;
            first = 1'b0;
        end
    endtask

    task automatic do_reset();
        cfg_valid = '0;
        ax_ready  = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_cmd(input int ch, input logic [31:0] sa, input logic [31:0] len,
                           input int stall_max, input bit fixed, input string tag);
        logic [1:0] oh;
        int t, stall;
        oh = (ch == 0) ? 2'b01 : 2'b10;
        build_model(sa, len);
        @(negedge clk);
        cfg_valid = oh;
        if (ch == 0) begin cfg_sa[31:0] = sa;  cfg_len[31:0] = len;  end
        else         begin cfg_sa[63:32] = sa; cfg_len[63:32] = len; end
        #1;
        n_cmp++;
        if (cfg_ready !== oh) begin
            n_err++;
            $display("FAIL %s cfg_ready got %b exp %b", tag, cfg_ready, oh);
            cfg_valid = '0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cfg_valid = '0;
        n_cmp++;
        if (ax_valid !== 1'b0 || done !== ((len == 0) ? oh : 2'b00)) begin
            n_err++;
            $display("FAIL %s post_accept ax_valid=%b done=%b exp 0/%b", tag, ax_valid, done,
                     (len == 0) ? oh : 2'b00);
        end
        for (int k = 0; k < exp_addr.size(); k++) begin
            t = 0;
            while (ax_valid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
            n_cmp++;
            if (t !== 1) begin
                n_err++;
                $display("FAIL %s burst%0d latency got %0d cycles exp 1", tag, k, t);
                if (ax_valid !== 1'b1) return;
            end
            n_cmp++;
            if (ax_id !== 8'(ch) || ax_addr !== exp_addr[k] || ax_len !== exp_len[k] ||
                ax_size !== 3'd4 || ax_burst !== 2'b01) begin
                n_err++;
                $display("FAIL %s burst%0d got id=%0d addr=%h len=%h size=%0d burst=%0d exp id=%0d addr=%h len=%h size=4 burst=1",
                         tag, k, ax_id, ax_addr, ax_len, ax_size, ax_burst, ch, exp_addr[k], exp_len[k]);
            end
            stall = fixed ? stall_max : $urandom_range(0, stall_max);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                n_cmp++;
                if (ax_valid !== 1'b1 || ax_addr !== exp_addr[k] || ax_len !== exp_len[k] || ax_id !== 8'(ch)) begin
                    n_err++;
                    $display("FAIL %s stall_hold%0d got v=%b addr=%h len=%h exp v=1 addr=%h len=%h",
                             tag, s, ax_valid, ax_addr, ax_len, exp_addr[k], exp_len[k]);
                end
            end
            ax_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ax_ready = 1'b0;
            n_cmp++;
            if (done !== ((k == exp_addr.size() - 1) ? oh : 2'b00) || ax_valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s done_after_burst%0d got done=%b v=%b exp done=%b v=0", tag, k, done, ax_valid,
                         (k == exp_addr.size() - 1) ? oh : 2'b00);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 2'b00 || busy !== 1'b0 || ax_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_after got done=%b busy=%b v=%b exp 00/0/0", tag, done, busy, ax_valid);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (ax_valid !== 1'b0 || busy !== 1'b0 || done !== 2'b00 || cfg_ready !== 2'b00 ||
            ax_addr !== 32'h0 || ax_len !== 8'h0 || ax_id !== 8'h0 || ax_size !== 3'd4 || ax_burst !== 2'b01) begin
            n_err++;
            $display("FAIL reset got v=%b busy=%b done=%b rdy=%b addr=%h len=%h id=%h size=%0d burst=%0d",
                     ax_valid, busy, done, cfg_ready, ax_addr, ax_len, ax_id, ax_size, ax_burst);
        end
        do_reset();
    endtask

    task automatic test_directed();
        run_cmd(0, 32'h0000_1000, 32'h0000_1000, 2, 1'b0, "dir_4k");
        run_cmd(0, 32'h0000_0F80, 32'h0000_0100, 2, 1'b0, "dir_cross");
        run_cmd(1, 32'h0000_2000, 32'h0000_3010, 1, 1'b0, "dir_multi");
        run_cmd(0, 32'h0000_3000, 32'h0000_0000, 0, 1'b0, "dir_len0");
        run_cmd(1, 32'hFFFF_FF00, 32'h0000_0200, 1, 1'b0, "dir_wrap");
        run_cmd(0, 32'h0000_500F, 32'h0000_0011, 1, 1'b0, "dir_lowbits");
`ifdef AMI_UNALIGNED_EN
        run_cmd(0, 32'h0000_1004, 32'h0000_0020, 1, 1'b0, "dir_unaligned");
`endif
    endtask

    task automatic test_stall();
        run_cmd(0, 32'h0000_1000, 32'h0000_0020, 10, 1'b1, "stall10");
    endtask

    task automatic test_random();
        logic [31:0] sa, len;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       sa = $urandom;
                1:       sa = ($urandom & 32'hFFFF_F000) | 32'h0000_0F00 | ($urandom & 32'hFF);
                default: sa = 32'hFFFF_E000 | ($urandom & 32'h1FFF);
            endcase
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(0, 64);
                1:       len = $urandom_range(1, 32'h4000);
                2:       len = $urandom_range(32'h0FF0, 32'h1010);
                default: len = $urandom_range(1, 32'h400);
            endcase
            run_cmd(int'($urandom_range(0, 1)), sa, len, 3, 1'b0, $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_back_to_back();
        int pend[2];
        int grants[$];
        int ids[$];
        int cyc;
        do_reset();
        cfg_sa  = {32'h0001_0000, 32'h0000_0000};
        cfg_len = {32'h0000_0040, 32'h0000_0040};
        pend[0] = 2;
        pend[1] = 2;
        cyc = 0;
        while ((grants.size() < 4 || ids.size() < 4) && cyc < 100) begin
            cfg_valid = {pend[1] > 0, pend[0] > 0};
            ax_ready  = 1'b1;
            #1;
            if (cfg_ready[0]) begin grants.push_back(0); pend[0]--; end
            if (cfg_ready[1]) begin grants.push_back(1); pend[1]--; end
            if (ax_valid) ids.push_back(int'(ax_id));
            @(negedge clk);
            cyc++;
        end
        cfg_valid = '0;
        ax_ready  = 1'b0;
        n_cmp++;
        if (grants.size() !== 4 || ids.size() !== 4) begin
            n_err++;
            $display("FAIL b2b_count got grants=%0d ids=%0d exp 4/4", grants.size(), ids.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size() && i < ids.size()) begin
                n_cmp++;
                if (grants[i] !== (i % 2) || ids[i] !== (i % 2)) begin
                    n_err++;
                    $display("FAIL b2b_order%0d got grant=%0d id=%0d exp %0d", i, grants[i], ids[i], i % 2);
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset();
        cfg_sa[63:32]  = 32'h0000_2000;
        cfg_len[63:32] = 32'h0000_3010;
        cfg_valid = 2'b10;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = '0;
        t = 0;
        while (ax_valid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        n_cmp++;
        if (ax_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_start ax_valid got %b exp 1", ax_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ax_valid !== 1'b0 || busy !== 1'b0 || done !== 2'b00 || ax_addr !== 32'h0 || ax_id !== 8'h0) begin
            n_err++;
            $display("FAIL rst_mid_async got v=%b busy=%b done=%b addr=%h id=%h exp 0/0/00/0/0",
                     ax_valid, busy, done, ax_addr, ax_id);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 2'b00 || ax_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_quiet%0d got done=%b v=%b exp 00/0", i, done, ax_valid);
            end
        end
        cfg_valid = 2'b11;
        #1;
        n_cmp++;
        if (cfg_ready !== 2'b01) begin
            n_err++;
            $display("FAIL rst_rr_ptr cfg_ready got %b exp 01", cfg_ready);
        end
        cfg_valid = '0;
        run_cmd(0, 32'h0000_1000, 32'h0000_1000, 1, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
